// File: rtl/vp_train_queue_pkg.sv
// Shared types for the value-prediction training queue.
`ifndef P_CONF_WIDTH
`define P_CONF_WIDTH 3
`endif

package vp_train_queue_pkg;

    localparam int unsigned CONF_W = `P_CONF_WIDTH;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned LANES  = 2;
    localparam int unsigned DROP_W = 16;

    // Retired prediction info, two lanes per cycle (lane 1 is younger)
    typedef struct packed {
        logic [LANES-1:0]             valid;
        logic [LANES-1:0]             misp;
        logic [LANES-1:0][XLEN-1:0]   pc;
        logic [LANES-1:0][XLEN-1:0]   result;
        logic [LANES-1:0][XLEN-1:0]   actual;
        logic [LANES-1:0][CONF_W-1:0] conf;
    } vp_pkt_t;

    // One training update headed for the value-predictor table
    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   value;
        logic [CONF_W-1:0] conf;
    } vp_upd_pkt_t;

    // Saturating add of up to two drops onto the 16-bit drop counter
    function automatic logic [DROP_W-1:0] sat_add_drop(input logic [DROP_W-1:0] a,
                                                       input logic [1:0]        b);
        logic [DROP_W:0] s;
        s = {1'b0, a} + (DROP_W+1)'(b);
        return s[DROP_W] ? {DROP_W{1'b1}} : s[DROP_W-1:0];
    endfunction

endpackage

// File: rtl/vp_train_queue_if.sv
// Table-update handshake plus queue status between the training queue and the VP table.
interface vp_train_queue_if
    import vp_train_queue_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CONF_WIDTH = CONF_W
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                  upd_valid;
    logic                  upd_ready;
    logic [XLEN-1:0]       upd_pc;
    logic [XLEN-1:0]       upd_value;
    logic [CONF_WIDTH-1:0] upd_conf;
    logic [CNT_W-1:0]      upd_count;
    logic [DROP_W-1:0]     drop_cnt;

    modport master (
        output upd_valid, upd_pc, upd_value, upd_conf, upd_count, drop_cnt,
        input  upd_ready
    );

    modport slave (
        input  upd_valid, upd_pc, upd_value, upd_conf, upd_count, drop_cnt,
        output upd_ready
    );

endinterface

// File: rtl/vp_upd_fifo.sv
// 2-write/1-read FIFO of training updates with occupancy and free-slot count.
module vp_upd_fifo
    import vp_train_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_l,
    input  logic [1:0]                   wr_en,     // thermometer: bit1 only with bit0
    input  vp_upd_pkt_t                  wr_data0,
    input  vp_upd_pkt_t                  wr_data1,
    input  logic                         rd_en,
    output vp_upd_pkt_t                  head,
    output logic                         valid,
    output logic [$clog2(DEPTH):0]       count,
    output logic [$clog2(DEPTH):0]       free_c
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    vp_upd_pkt_t      mem [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_nxt;
    logic [CNT_W-1:0] nwr;
    logic             valid_q;
    logic             rd;

    // Occupancy bookkeeping; a read is only honoured when an entry is present
    always_comb begin
        rd        = rd_en & valid_q;
        nwr       = CNT_W'(wr_en[0]) + CNT_W'(wr_en[1]);
        count_nxt = count_q + nwr - CNT_W'(rd);
        free_c    = CNT_W'(DEPTH) - count_q + CNT_W'(rd);
    end

    // Storage; entries are cleared on reset so the head reads zero
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en[0]) mem[wptr_q] <= wr_data0;
            if (wr_en[1]) mem[wptr_q + PTR_W'(1)] <= wr_data1;
        end
    end

    // Pointers wrap modulo DEPTH; the separate counter disambiguates full/empty
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_q + PTR_W'(nwr);
            rptr_q  <= rptr_q + PTR_W'(rd);
            count_q <= count_nxt;
            valid_q <= (count_nxt != '0);
        end
    end

    assign head  = mem[rptr_q];
    assign valid = valid_q;
    assign count = count_q;

endmodule

// File: rtl/vp_train_queue.sv
// Value-prediction training queue: computes per-lane updates, coalesces, buffers, drains.
module vp_train_queue
    import vp_train_queue_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CONF_WIDTH = CONF_W
) (
    input  logic                    clk,
    input  logic                    rst_l,
    input  vp_pkt_t                 vp_pkt,
    vp_train_queue_if.master        upd
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    vp_upd_pkt_t           lane_upd [LANES];
    logic [CONF_WIDTH-1:0] conf_in  [LANES];
    logic [CONF_WIDTH-1:0] conf_out [LANES];
    logic                  coalesce;
    logic                  cand0;
    logic                  cand1;
    vp_upd_pkt_t           slot0;
    vp_upd_pkt_t           slot1;
    logic [1:0]            n_cand;
    logic [1:0]            n_acc;
    logic [1:0]            n_drop;
    logic [1:0]            wr_en;
    logic                  rd_en;
    vp_upd_pkt_t           head;
    logic                  fifo_valid;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W-1:0]      fifo_free;
    logic [DROP_W-1:0]     drop_q;

    // New value/confidence per lane: misprediction resets, hit bumps with saturation
    always_comb begin
        for (int i = 0; i < int'(LANES); i++) begin
            conf_in[i]  = CONF_WIDTH'(vp_pkt.conf[i]);
            conf_out[i] = '0;
            if (!vp_pkt.misp[i]) begin
                conf_out[i] = (&conf_in[i]) ? conf_in[i] : conf_in[i] + CONF_WIDTH'(1);
            end
            lane_upd[i].pc    = vp_pkt.pc[i];
            lane_upd[i].value = vp_pkt.misp[i] ? vp_pkt.actual[i] : vp_pkt.result[i];
            lane_upd[i].conf  = CONF_W'(conf_out[i]);
        end
    end

    // Coalesce same-PC lanes, compact candidates oldest-first, accept what fits
    always_comb begin
        coalesce = vp_pkt.valid[0] & vp_pkt.valid[1] & (vp_pkt.pc[0] == vp_pkt.pc[1]);
        cand0    = vp_pkt.valid[0] & ~coalesce;
        cand1    = vp_pkt.valid[1];
        slot0    = cand0 ? lane_upd[0] : lane_upd[1];
        slot1    = lane_upd[1];
        n_cand   = 2'(cand0) + 2'(cand1);
        n_acc    = n_cand;
        if (CNT_W'(n_cand) > fifo_free) begin
            n_acc = 2'(fifo_free);
        end
        n_drop   = n_cand - n_acc;
        wr_en    = {n_acc[1], n_acc[1] | n_acc[0]};
        rd_en    = fifo_valid & upd.upd_ready;
    end

    vp_upd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_l    (rst_l),
        .wr_en    (wr_en),
        .wr_data0 (slot0),
        .wr_data1 (slot1),
        .rd_en    (rd_en),
        .head     (head),
        .valid    (fifo_valid),
        .count    (fifo_count),
        .free_c   (fifo_free)
    );

    // Saturating count of updates rejected for lack of space
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            drop_q <= '0;
        end else begin
            drop_q <= sat_add_drop(drop_q, n_drop);
        end
    end

    assign upd.upd_valid = fifo_valid;
    assign upd.upd_pc    = head.pc;
    assign upd.upd_value = head.value;
    assign upd.upd_conf  = head.conf;
    assign upd.upd_count = fifo_count;
    assign upd.drop_cnt  = drop_q;

endmodule

// File: doc/vp_train_queue.md
# vp_train_queue

Value-prediction training queue; sits directly downstream of the retirement stage that produces `vp_pkt_t` (two lanes per cycle). It computes each retired lane's new confidence and training value, then buffers the updates in a small FIFO. It drains them one per cycle to the single-write-port value-predictor table through a valid/ready handshake. Training is a hint path: overflow drops updates rather than stalling retirement.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries (power of two, ≥2).
- `CONF_WIDTH`, `` `P_CONF_WIDTH ``: confidence counter width.

Ports:
- `clk`  in  1  core clock.
- `rst_l`  in  1  reset, asynchronous, active-low.
- `vp_pkt`  in  `vp_pkt_t`  retired prediction info: per lane `valid`, `misp`, `pc`, `result`, `actual`, `conf`.
- `upd_valid`  out  1  head entry valid.
- `upd_ready`  in  1  table accepts the head entry this cycle.
- `upd_pc`  out  32  head entry PC.
- `upd_value`  out  32  head entry training value.
- `upd_conf`  out  CONF_WIDTH  head entry new confidence.
- `upd_count`  out  $clog2(DEPTH)+1  current occupancy.
- `drop_cnt`  out  16  saturating count of dropped updates.

## Operation
- Per lane `i` with `valid[i]=1`, compute:
  - `misp[i]=1`: value=`actual[i]`, conf=0.
  - `misp[i]=0`: value=`result[i]`, conf=`conf[i]`+1, saturating at all-ones.
- Coalescing: if both lanes are valid and `pc[0]==pc[1]`, lane 0 is discarded, because it is superseded by younger lane 1. A coalesced discard does not increment `drop_cnt`.
- Enqueue order: lane 0 first, then lane 1, into consecutive slots.
- Free slots: `free = DEPTH - count + (upd_valid & upd_ready)`. A same-cycle dequeue frees a slot.
- If fewer free slots than candidates, enqueue the oldest candidates that fit. Each rejected candidate increments `drop_cnt` by 1; `drop_cnt` saturates at 16'hFFFF.
- Dequeue occurs when `upd_valid & upd_ready`; the head pointer advances.
- Read and write pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. Occupancy is held in a separate counter, so full and empty are unambiguous.
- Lanes with `valid=0` are ignored regardless of other fields.

## Timing
- Reset (async assert, synchronous deassert by the clock domain):
  - `upd_valid=0`, `upd_count=0`, `drop_cnt=0`, pointers 0.
  - `upd_pc`, `upd_value`, `upd_conf` = 0.
- Latency: an update enqueued at edge N is visible on `upd_*` after edge N, i.e. in cycle N+1 when the FIFO was empty. There is no combinational bypass from `vp_pkt` to the outputs.
- `upd_*` outputs are stable while `upd_valid & ~upd_ready`. `upd_valid` never drops without a handshake.
- Full with dequeue and enqueue in the same cycle: one slot frees, one lane is accepted, and `count` stays at DEPTH.
- Empty with two valid lanes: `count` goes 0→2 in one cycle.
- Reset asserted mid-operation: all contents are discarded immediately, and outputs go to reset values asynchronously.

## Structure
- Add `vp_upd_pkt_t {pc[31:0], value[31:0], conf[P_CONF_WIDTH-1:0]}` to `swerv_types`, next to `vp_pkt_t`, under `VP_ENABLED`.
- `P_CONF_WIDTH` stays a global define.
- One sub-module, `vp_upd_fifo`: a parameterised 2-write/1-read FIFO of `vp_upd_pkt_t` with write enables, occupancy, and free-slot output.
- The top level holds the confidence/value computation, coalescing, and the drop counter.

## Test plan
- **Reset/idle:** hold `rst_l=0` then release with `vp_pkt.valid=0` → `upd_valid=0`, `upd_count=0`, `drop_cnt=0`.
- **Correct prediction, lane 0:** pc=0x1000, result=0x55, conf=2, misp=0 → next cycle `upd_pc`=0x1000, `upd_value`=0x55, `upd_conf`=3.
- **Misprediction and saturation:**
  - Lane 1 with misp=1, actual=0xAB → `upd_value`=0xAB, `upd_conf`=0.
  - Lane 0 with conf=all-ones, misp=0 → `upd_conf`=all-ones.
- **Coalescing:** both lanes valid with pc=0x2000, lane1 result=0x7 → only one entry, value 0x7, and `drop_cnt` unchanged.
- **Overflow:**
  - Hold `upd_ready=0` and send two lanes per cycle for 3 cycles (DEPTH=4) → `upd_count`=4, `drop_cnt`=2, head = first lane-0 update.
- **Full with simultaneous dequeue/enqueue:** at full, `upd_ready=1` with one new lane → `upd_count` stays 4, head advances, and the new entry is at the tail.
